// File: rtl/div_unit_if.sv
// div_unit_if: request and result bundle between the EX stage and div_unit.
// The master modport drives the request side. The slave modport is the divider.
interface div_unit_if #(
  parameter int WIDTH = 32
);
  logic             i_start;
  logic             i_signed;
  logic [WIDTH-1:0] i_dividend;
  logic [WIDTH-1:0] i_divisor;
  logic             i_cancel;
  logic [WIDTH-1:0] o_quotient;
  logic [WIDTH-1:0] o_remainder;
  logic             o_valid;
  logic             o_div_by_zero;
  logic             o_stall;

  modport master (
    output i_start, i_signed, i_dividend, i_divisor, i_cancel,
    input  o_quotient, o_remainder, o_valid, o_div_by_zero, o_stall
  );

  modport slave (
    input  i_start, i_signed, i_dividend, i_divisor, i_cancel,
    output o_quotient, o_remainder, o_valid, o_div_by_zero, o_stall
  );
endinterface

// File: rtl/div_unit.sv
// div_unit: iterative restoring divider that retires one quotient bit per cycle.
// The latency is fixed at WIDTH cycles. Division by zero takes a single cycle.
// Optional macro DIV_SIGNED_EN adds signed operand and result correction.
// Without DIV_SIGNED_EN, i_signed is ignored and every operation is unsigned.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst,
  div_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ZERO = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;
`ifdef DIV_SIGNED_EN
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic             a_neg, b_neg;
`endif

  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   shifted, trial, step_rem;
  logic [WIDTH-1:0] step_quo, fix_quo, fix_rem;

  // Operand magnitudes. In signed mode, negative operands are negated before the iteration.
  always_comb begin
`ifdef DIV_SIGNED_EN
    a_neg = bus.i_signed & bus.i_dividend[WIDTH-1];
    b_neg = bus.i_signed & bus.i_divisor[WIDTH-1];
    a_mag = a_neg ? (-bus.i_dividend) : bus.i_dividend;
    b_mag = b_neg ? (-bus.i_divisor) : bus.i_divisor;
`else
    a_mag = bus.i_dividend;
    b_mag = bus.i_divisor;
`endif
  end

  // One restoring step: shift in the next dividend bit and trial-subtract the divisor.
  // The MSB of the (WIDTH+1)-bit difference acts as the borrow.
  always_comb begin
    shifted = (rem_q << 1) | {{WIDTH{1'b0}}, quo_q[WIDTH-1]};
    trial   = shifted - {1'b0, dvs_q};
    if (!trial[WIDTH]) begin
      step_rem = trial;
      step_quo = {quo_q[WIDTH-2:0], 1'b1};
    end else begin
      step_rem = shifted;
      step_quo = {quo_q[WIDTH-2:0], 1'b0};
    end
`ifdef DIV_SIGNED_EN
    fix_quo = q_neg_q ? (-step_quo) : step_quo;
    fix_rem = r_neg_q ? (-step_rem[WIDTH-1:0]) : step_rem[WIDTH-1:0];
`else
    fix_quo = step_quo;
    fix_rem = step_rem[WIDTH-1:0];
`endif
  end

  // FSM next state, datapath updates and result register loads.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
`ifdef DIV_SIGNED_EN
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.i_start && !bus.i_cancel) begin
          cnt_d = '0;
          rem_d = '0;
          dvs_d = b_mag;
          if (bus.i_divisor == '0) begin
            // The raw dividend is kept so that it can be returned as the remainder.
            state_d = ZERO;
            quo_d   = bus.i_dividend;
          end else begin
            state_d = RUN;
            quo_d   = a_mag;
`ifdef DIV_SIGNED_EN
            q_neg_d = a_neg ^ b_neg;
            r_neg_d = a_neg;
`endif
          end
        end
      end
      ZERO: begin
        if (bus.i_cancel) begin
          state_d = IDLE;
        end else begin
          state_d     = DONE;
          quotient_d  = '1;
          remainder_d = quo_q;
          dbz_d       = 1'b1;
        end
      end
      RUN: begin
        if (bus.i_cancel) begin
          state_d = IDLE;
        end else begin
          rem_d = step_rem;
          quo_d = step_quo;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_d     = DONE;
            quotient_d  = fix_quo;
            remainder_d = fix_rem;
            dbz_d       = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // All state registers. Reset is asynchronous and active-low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
`ifdef DIV_SIGNED_EN
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
`ifdef DIV_SIGNED_EN
      q_neg_q     <= q_neg_d;
      r_neg_q     <= r_neg_d;
`endif
    end
  end

  // The stall output is gated by reset so that every output reads zero while reset is held.
  assign bus.o_stall       = rst & ((state_q == IDLE && bus.i_start && !bus.i_cancel) ||
                                    state_q == RUN || state_q == ZERO);
  assign bus.o_valid       = (state_q == DONE);
  assign bus.o_quotient    = quotient_q;
  assign bus.o_remainder   = remainder_q;
  assign bus.o_div_by_zero = dbz_q;
endmodule
